// File: rtl/button_debouncer.sv
// Push-button debouncer: clean level plus press/release/hold event pulses.
// Define BUTTON_DEBOUNCER_HOLD_EN to build in the long-press (hold_pulse) detector.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned HOLD_CYCLES     = 100_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_sync,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_pulse
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StPressed,
        StReleaseWait
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          press_accept;
    logic          release_accept;

    assign press_accept   = (state_q == StPressWait) && btn_sync && (cnt_q == CNT_LAST);
    assign release_accept = (state_q == StReleaseWait) && !btn_sync && (cnt_q == CNT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (btn_sync) begin
                        state_q <= StPressWait;
                        cnt_q   <= CW'(1);
                    end
                end
                StPressWait: begin
                    if (!btn_sync) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (press_accept) begin
                        state_q     <= StPressed;
                        cnt_q       <= '0;
                        btn_level   <= 1'b1;
                        press_pulse <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StPressed: begin
                    if (!btn_sync) begin
                        state_q <= StReleaseWait;
                        cnt_q   <= CW'(1);
                    end
                end
                StReleaseWait: begin
                    if (btn_sync) begin
                        state_q <= StPressed;
                        cnt_q   <= '0;
                    end else if (release_accept) begin
                        state_q       <= StIdle;
                        cnt_q         <= '0;
                        btn_level     <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    cnt_q     <= '0;
                    btn_level <= 1'b0;
                end
            endcase
        end
    end

`ifdef BUTTON_DEBOUNCER_HOLD_EN
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_CYCLES - 1);

    logic [HW-1:0] hold_cnt_q;
    logic          in_held;

    assign in_held = (state_q == StPressed) || (state_q == StReleaseWait);

    // An accepted release clears the count and wins over a coincident hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_cnt_q <= '0;
            hold_pulse <= 1'b0;
        end else begin
            hold_pulse <= 1'b0;
            if (press_accept || release_accept) begin
                hold_cnt_q <= '0;
            end else if (in_held && (hold_cnt_q != HOLD_MAX)) begin
                hold_cnt_q <= hold_cnt_q + HW'(1);
                if (hold_cnt_q == HOLD_PRE) begin
                    hold_pulse <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_hold_cfg;
    assign unused_hold_cfg = ^HOLD_CYCLES;
    assign hold_pulse      = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed self-checking bench for button_debouncer (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10).
module tb_button_debouncer;

    logic clock;
    logic reset;
    logic btn_sync;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic hold_pulse;

    int checks   = 0;
    int failures = 0;

`ifdef BUTTON_DEBOUNCER_HOLD_EN
    localparam logic HOLD_EN = 1'b1;
`else
    localparam logic HOLD_EN = 1'b0;
`endif

    // Expected output vectors: {btn_level, press_pulse, release_pulse, hold_pulse}
    localparam logic [3:0] OUT_IDLE  = 4'b0000;
    localparam logic [3:0] OUT_LEVEL = 4'b1000;
    localparam logic [3:0] OUT_PRESS = 4'b1100;
    localparam logic [3:0] OUT_REL   = 4'b0010;

    button_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (10)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .btn_sync     (btn_sync),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .hold_pulse   (hold_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got lvl/prs/rel/hld=%b expected %b", tag, got, exp);
        end
    endtask

    task automatic step(input logic b, input logic [3:0] exp, input string tag);
        btn_sync = b;
        @(posedge clock);
        #1;
        check(tag, {btn_level, press_pulse, release_pulse, hold_pulse}, exp);
    endtask

    initial begin
        logic [3:0] hold_exp;
        hold_exp = {1'b1, 1'b0, 1'b0, HOLD_EN};
        reset    = 1'b0;
        btn_sync = 1'b0;

        #1 check("in_reset", {btn_level, press_pulse, release_pulse, hold_pulse}, OUT_IDLE);
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        step(1'b0, OUT_IDLE, "after_reset");

        // Clean press, long hold with one release glitch, clean release
        for (int i = 1; i <= 3; i++) step(1'b1, OUT_IDLE, "press_window");
        step(1'b1, OUT_PRESS, "clean_press");
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, (i == 10) ? hold_exp : OUT_LEVEL, (i == 10) ? "hold_fire" : "hold_wait");
        end
        step(1'b0, OUT_LEVEL, "rel_glitch0");
        step(1'b1, OUT_LEVEL, "rel_glitch1");
        for (int i = 1; i <= 3; i++) step(1'b0, OUT_LEVEL, "release_window");
        step(1'b0, OUT_REL, "release_after_hold");
        step(1'b0, OUT_IDLE, "idle_after_release");

        // Bounce 1,1,0,1,1,1,1 restarts the window
        step(1'b1, OUT_IDLE, "bounce_1");
        step(1'b1, OUT_IDLE, "bounce_2");
        step(1'b0, OUT_IDLE, "bounce_0");
        for (int i = 1; i <= 3; i++) step(1'b1, OUT_IDLE, "bounce_rewait");
        step(1'b1, OUT_PRESS, "bounce_press");

        // Short press: released 5 cycles after press, no hold
        for (int i = 1; i <= 4; i++) step(1'b1, OUT_LEVEL, "short_held");
        for (int i = 1; i <= 3; i++) step(1'b0, OUT_LEVEL, "short_rel_window");
        step(1'b0, OUT_REL, "short_release");
        for (int i = 1; i <= 8; i++) step(1'b0, OUT_IDLE, "short_no_hold");

        // Reset while pressed, input stays high through and after reset
        for (int i = 1; i <= 3; i++) step(1'b1, OUT_IDLE, "pre_reset_window");
        step(1'b1, OUT_PRESS, "pre_reset_press");
        step(1'b1, OUT_LEVEL, "pre_reset_held");
        step(1'b1, OUT_LEVEL, "pre_reset_held");
        #2 reset = 1'b0;
        #1 check("async_reset", {btn_level, press_pulse, release_pulse, hold_pulse}, OUT_IDLE);
        @(posedge clock);
        #1 check("reset_held", {btn_level, press_pulse, release_pulse, hold_pulse}, OUT_IDLE);
        #2 reset = 1'b1;
        for (int i = 1; i <= 3; i++) step(1'b1, OUT_IDLE, "post_reset_window");
        step(1'b1, OUT_PRESS, "post_reset_press");
        step(1'b1, OUT_LEVEL, "post_reset_held");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
